// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter giving a CPU port and a debug/loader port single-cycle access to one data memory.
module dmem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, CPU_ACC, DBG_ACC} stateT;
    stateT             state, nextState;
    logic              lastGrant;
    logic              pickCpu;
    logic              cmdWe;
    logic [ADDR_W-1:0] cmdAddr;
    logic [DATA_W-1:0] cmdWdata;
    // lastGrant: 0 = CPU, 1 = DBG; on a tie the port that did not go last wins
    always_comb begin
        pickCpu   = cpu_req & (~dbg_req | lastGrant);
        nextState = (state == CPU_ACC) ? (dbg_req ? DBG_ACC : IDLE)
                  : (state == DBG_ACC) ? (cpu_req ? CPU_ACC : IDLE)
                  : pickCpu ? CPU_ACC : dbg_req ? DBG_ACC : IDLE;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            lastGrant <= 1'b1;
            cmdWe     <= 1'b0;
            cmdAddr   <= '0;
            cmdWdata  <= '0;
        end else begin
            state <= nextState;
            if (nextState == CPU_ACC) begin
                cmdAddr   <= cpu_addr;
                cmdWe     <= cpu_we;
                cmdWdata  <= cpu_wdata;
                lastGrant <= 1'b0;
            end else if (nextState == DBG_ACC) begin
                cmdAddr   <= dbg_addr;
                cmdWe     <= dbg_we;
                cmdWdata  <= dbg_wdata;
                lastGrant <= 1'b1;
            end
        end
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
        end else begin
            cpu_rvalid <= cpu_gnt & ~cmdWe;
            dbg_rvalid <= dbg_gnt & ~cmdWe;
            if (cpu_gnt & ~cmdWe) cpu_rdata <= mem_rdata;
            if (dbg_gnt & ~cmdWe) dbg_rdata <= mem_rdata;
        end
    end
    assign cpu_gnt   = (state == CPU_ACC);
    assign dbg_gnt   = (state == DBG_ACC);
    assign mem_we    = (cpu_gnt | dbg_gnt) & cmdWe;
    assign mem_re    = (cpu_gnt | dbg_gnt) & ~cmdWe;
    assign mem_addr  = cmdAddr;
    assign mem_wdata = cmdWdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter against a behavioural 32-word memory.
module tb_dmem_arbiter;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
    logic [4:0]  cpu_addr = '0, dbg_addr = '0, mem_addr;
    logic [31:0] cpu_wdata = '0, dbg_wdata = '0, mem_wdata, mem_rdata, cpu_rdata, dbg_rdata;
    logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_we, mem_re;
    logic [31:0] memArr [0:31];
    int          numChecks = 0;
    int          numFails = 0;

    dmem_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;
    assign mem_rdata = memArr[mem_addr];
    always @(posedge CLK) if (mem_we) memArr[mem_addr] <= mem_wdata;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numFails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkEq({tag, ".cpu_gnt"}, cpu_gnt, 0);
        checkEq({tag, ".dbg_gnt"}, dbg_gnt, 0);
        checkEq({tag, ".cpu_rvalid"}, cpu_rvalid, 0);
        checkEq({tag, ".dbg_rvalid"}, dbg_rvalid, 0);
        checkEq({tag, ".mem_we"}, mem_we, 0);
        checkEq({tag, ".mem_re"}, mem_re, 0);
        checkEq({tag, ".mem_addr"}, mem_addr, 0);
        checkEq({tag, ".mem_wdata"}, mem_wdata, 0);
        checkEq({tag, ".cpu_rdata"}, cpu_rdata, 0);
        checkEq({tag, ".dbg_rdata"}, dbg_rdata, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) memArr[i] = '0;
        memArr[1] = 32'h1111_1111;
        memArr[2] = 32'h2222_2222;
        memArr[4] = 32'hA4A4_A4A4;
        memArr[9] = 32'h9999_9999;
        // both ports request reads from reset onward
        cpu_req = 1'b1; cpu_addr = 5'd1;
        dbg_req = 1'b1; dbg_addr = 5'd2;
        #1;
        checkAllZero("reset");
        step();
        checkAllZero("reset_held");
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checkEq($sformatf("alt%0d.cpu_gnt", i), cpu_gnt, (i % 2 == 0) ? 1 : 0);
            checkEq($sformatf("alt%0d.dbg_gnt", i), dbg_gnt, (i % 2 == 1) ? 1 : 0);
            checkEq($sformatf("alt%0d.cpu_rvalid", i), cpu_rvalid, (i % 2 == 1) ? 1 : 0);
            checkEq($sformatf("alt%0d.dbg_rvalid", i), dbg_rvalid, (i == 2) ? 1 : 0);
            checkEq($sformatf("alt%0d.mem_addr", i), mem_addr, (i % 2 == 0) ? 1 : 2);
        end
        checkEq("alt.cpu_rdata", cpu_rdata, 32'h1111_1111);
        cpu_req = 1'b0; dbg_req = 1'b0;
        step();
        checkEq("alt_end.dbg_rvalid", dbg_rvalid, 1);
        checkEq("alt_end.cpu_rvalid", cpu_rvalid, 0);
        checkEq("alt_end.dbg_rdata", dbg_rdata, 32'h2222_2222);
        checkEq("alt_end.gnt", {cpu_gnt, dbg_gnt}, 0);

        // CPU write addr 3
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd3; cpu_wdata = 32'hDEAD_BEEF;
        step();
        checkEq("wr.cpu_gnt", cpu_gnt, 1);
        checkEq("wr.mem_we", mem_we, 1);
        checkEq("wr.mem_re", mem_re, 0);
        checkEq("wr.mem_addr", mem_addr, 3);
        checkEq("wr.mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        cpu_req = 1'b0;
        step();
        checkEq("wr.cpu_rvalid", cpu_rvalid, 0);
        checkEq("wr.mem_we_after", mem_we, 0);
        checkEq("wr.mem3", memArr[3], 32'hDEAD_BEEF);
        checkEq("wr.rdata_held", cpu_rdata, 32'h1111_1111);

        // CPU read addr 3
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd3;
        step();
        checkEq("rd.cpu_gnt", cpu_gnt, 1);
        checkEq("rd.mem_re", mem_re, 1);
        checkEq("rd.mem_we", mem_we, 0);
        checkEq("rd.rvalid_early", cpu_rvalid, 0);
        cpu_req = 1'b0;
        step();
        checkEq("rd.cpu_rvalid", cpu_rvalid, 1);
        checkEq("rd.cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        checkEq("rd.mem_re_after", mem_re, 0);
        step();
        checkEq("rd.rvalid_pulse", cpu_rvalid, 0);
        checkEq("rd.rdata_hold", cpu_rdata, 32'hDEAD_BEEF);

        // dbg write addr 7, CPU read of addr 7 requested during dbg's access
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'h1234_5678;
        step();
        checkEq("dwr.dbg_gnt", dbg_gnt, 1);
        checkEq("dwr.mem_we", mem_we, 1);
        dbg_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd7;
        step();
        checkEq("dwr.cpu_gnt_next", cpu_gnt, 1);
        checkEq("dwr.mem_addr", mem_addr, 7);
        checkEq("dwr.mem_re", mem_re, 1);
        checkEq("dwr.dbg_rvalid", dbg_rvalid, 0);
        cpu_req = 1'b0;
        step();
        checkEq("dwr.cpu_rvalid", cpu_rvalid, 1);
        checkEq("dwr.cpu_rdata", cpu_rdata, 32'h1234_5678);
        checkEq("dwr.dbg_rdata_held", dbg_rdata, 32'h2222_2222);

        // address change after latching must not affect the access
        cpu_req = 1'b1; cpu_addr = 5'd4;
        step();
        cpu_addr = 5'd9; cpu_req = 1'b0;
        #1;
        checkEq("latch.mem_addr", mem_addr, 4);
        step();
        checkEq("latch.cpu_rdata", cpu_rdata, 32'hA4A4_A4A4);

        // reset pulsed mid-cycle during a CPU write to addr 5
        step();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd5; cpu_wdata = 32'hBADC_0DE5;
        step();
        checkEq("rst.mem_we_before", mem_we, 1);
        #2 RST = 1'b1;
        #1;
        checkAllZero("rst_mid");
        cpu_req = 1'b0; cpu_we = 1'b0;
        step();
        checkAllZero("rst_edge");
        checkEq("rst.mem5", memArr[5], 0);
        RST = 1'b0;
        step();
        checkEq("rst.no_rvalid", cpu_rvalid, 0);
        cpu_req = 1'b1; cpu_addr = 5'd5;
        step();
        checkEq("rst.rd_gnt", cpu_gnt, 1);
        cpu_req = 1'b0;
        step();
        checkEq("rst.rd_rvalid", cpu_rvalid, 1);
        checkEq("rst.rd_rdata", cpu_rdata, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

    always @(negedge CLK)
        if (cpu_rvalid && dbg_rvalid) begin
            numFails++;
            $display("FAIL rvalid_excl: got both rvalid high, expected at most one");
        end
endmodule
